// File: rtl/bp_fe_bht_update_fifo_pkg.sv
// Shared types and sizing helpers for the BHT training-update FIFO.
package bp_fe_bht_update_fifo_pkg;

  localparam int bht_idx_width_gp    = 9;
  localparam int bht_offset_width_gp = 2;
  localparam int bht_row_width_gp    = 8;

  // One BHT training update, shared with the training producer.
  typedef struct packed {
    logic [bht_idx_width_gp-1:0]    idx;
    logic [bht_offset_width_gp-1:0] offset;
    logic [bht_row_width_gp-1:0]    val;
    logic                           correct;
  } bp_fe_bht_update_s;

  // Bits needed to hold the values 0..n inclusive.
  function automatic int bsg_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/bp_fe_bht_update_fifo_chk.sv
// Simulation checks on the BHT write handshake.
module bp_fe_bht_update_fifo_chk (
  input logic clk_i,
  input logic reset_i,
  input logic w_v_i,
  input logic w_yumi_i
);

  yumi_needs_valid_a: assert property (@(posedge clk_i) disable iff (reset_i)
    !(w_yumi_i && !w_v_i));

endmodule

// File: rtl/bp_fe_bht_update_fifo_mem.sv
// Entry storage: one synchronous write port, one asynchronous read port.
module bp_fe_bht_update_fifo_mem
  import bp_fe_bht_update_fifo_pkg::*;
#(
  parameter int els_p = 4
)(
  input  logic                     clk_i,
  input  logic                     w_v_i,
  input  logic [$clog2(els_p)-1:0] w_addr_i,
  input  bp_fe_bht_update_s        w_data_i,
  input  logic [$clog2(els_p)-1:0] r_addr_i,
  output bp_fe_bht_update_s        r_data_o
);

  bp_fe_bht_update_s mem_q [els_p];

  // Write port; reads of the same row this cycle see the old contents.
  always_ff @(posedge clk_i) begin
    if (w_v_i) begin
      mem_q[w_addr_i] <= w_data_i;
    end
  end

  assign r_data_o = mem_q[r_addr_i];

endmodule

// File: rtl/bp_fe_bht_update_fifo.sv
// In-order buffer of BHT training updates with starvation-driven write forcing.
// Optional tail coalescing is enabled by defining BP_FE_BHT_UPD_COALESCE_EN.
module bp_fe_bht_update_fifo
  import bp_fe_bht_update_fifo_pkg::*;
#(
  parameter int els_p          = 4,
  parameter int starve_limit_p = 3
)(
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic                                 init_done_i,

  input  logic                                 enq_v_i,
  output logic                                 enq_ready_and_o,
  input  logic [bht_idx_width_gp-1:0]          enq_idx_i,
  input  logic [bht_offset_width_gp-1:0]       enq_offset_i,
  input  logic [bht_row_width_gp-1:0]          enq_val_i,
  input  logic                                 enq_correct_i,

  output logic                                 w_v_o,
  output logic [bht_idx_width_gp-1:0]          w_idx_o,
  output logic [bht_offset_width_gp-1:0]       w_offset_o,
  output logic [bht_row_width_gp-1:0]          w_val_o,
  output logic                                 w_correct_o,
  output logic                                 w_force_o,
  input  logic                                 w_yumi_i,

  output logic [bsg_width(els_p)-1:0]          count_o
);

  localparam int ptr_w_lp = $clog2(els_p);
  localparam int cnt_w_lp = bsg_width(els_p);
  localparam int stv_w_lp = bsg_width(starve_limit_p);

  logic [ptr_w_lp-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [cnt_w_lp-1:0] count_q, count_d;
  logic [stv_w_lp-1:0] starve_q, starve_d;

  logic full_s, empty_s, enq_fire_s, alloc_s, coalesce_s, deq_s, starved_s;
  logic                mem_w_v_s;
  logic [ptr_w_lp-1:0] mem_w_addr_s;
  bp_fe_bht_update_s   enq_entry_s, head_s;

  assign full_s    = (count_q == cnt_w_lp'(els_p));
  assign empty_s   = (count_q == {cnt_w_lp{1'b0}});
  assign starved_s = (starve_q == stv_w_lp'(starve_limit_p));

  assign enq_entry_s = '{idx: enq_idx_i, offset: enq_offset_i,
                         val: enq_val_i, correct: enq_correct_i};

`ifdef BP_FE_BHT_UPD_COALESCE_EN
  // Key of the youngest entry, so a repeat update can merge into it.
  logic [bht_idx_width_gp+bht_offset_width_gp-1:0] tail_key_q;
  logic [ptr_w_lp-1:0] tail_ptr_s;
  logic tail_match_s, tail_is_head_s;

  assign tail_ptr_s     = wptr_q - ptr_w_lp'(1);
  assign tail_match_s   = ~empty_s & (tail_key_q == {enq_idx_i, enq_offset_i});
  assign tail_is_head_s = (count_q == cnt_w_lp'(1));
  // A head leaving this cycle cannot absorb the update; allocate instead.
  assign coalesce_s      = enq_v_i & tail_match_s & ~(tail_is_head_s & w_yumi_i);
  assign enq_ready_and_o = ~full_s | tail_match_s;
  assign mem_w_addr_s    = coalesce_s ? tail_ptr_s : wptr_q;

  // Track the tail key on every allocation.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tail_key_q <= {(bht_idx_width_gp+bht_offset_width_gp){1'b0}};
    end else if (alloc_s) begin
      tail_key_q <= {enq_idx_i, enq_offset_i};
    end else begin
      tail_key_q <= tail_key_q;
    end
  end
`else
  assign coalesce_s      = 1'b0;
  assign enq_ready_and_o = ~full_s;
  assign mem_w_addr_s    = wptr_q;
`endif

  assign enq_fire_s = enq_v_i & enq_ready_and_o;
  assign alloc_s    = enq_fire_s & ~coalesce_s;
  assign mem_w_v_s  = alloc_s | coalesce_s;

  // Nothing is offered to the BHT during the reset cycle.
  assign w_v_o     = ~empty_s & init_done_i & ~reset_i;
  assign w_force_o = w_v_o & starved_s;
  assign deq_s     = w_yumi_i & w_v_o;

  bp_fe_bht_update_fifo_mem #(.els_p(els_p)) mem (
    .clk_i    (clk_i),
    .w_v_i    (mem_w_v_s),
    .w_addr_i (mem_w_addr_s),
    .w_data_i (enq_entry_s),
    .r_addr_i (rptr_q),
    .r_data_o (head_s)
  );

  assign w_idx_o     = head_s.idx;
  assign w_offset_o  = head_s.offset;
  assign w_val_o     = head_s.val;
  assign w_correct_o = head_s.correct;
  assign count_o     = count_q;

  // Pointer, occupancy and head-age next state.
  always_comb begin
    rptr_d   = rptr_q;
    wptr_d   = wptr_q;
    count_d  = count_q;
    starve_d = starve_q;

    if (alloc_s) begin
      wptr_d = wptr_q + ptr_w_lp'(1);
    end else begin
      wptr_d = wptr_q;
    end

    if (deq_s) begin
      rptr_d = rptr_q + ptr_w_lp'(1);
    end else begin
      rptr_d = rptr_q;
    end

    unique case ({alloc_s, deq_s})
      2'b10:   count_d = count_q + cnt_w_lp'(1);
      2'b01:   count_d = count_q - cnt_w_lp'(1);
      default: count_d = count_q;
    endcase

    // Age counts only cycles the head is actually offered and refused.
    if (deq_s) begin
      starve_d = {stv_w_lp{1'b0}};
    end else if (w_v_o && !starved_s) begin
      starve_d = starve_q + stv_w_lp'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  // State registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rptr_q   <= {ptr_w_lp{1'b0}};
      wptr_q   <= {ptr_w_lp{1'b0}};
      count_q  <= {cnt_w_lp{1'b0}};
      starve_q <= {stv_w_lp{1'b0}};
    end else begin
      rptr_q   <= rptr_d;
      wptr_q   <= wptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
    end
  end

  bp_fe_bht_update_fifo_chk chk (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .w_v_i    (w_v_o),
    .w_yumi_i (w_yumi_i)
  );

endmodule

// File: tb/tb_bp_fe_bht_update_fifo.sv
// Scoreboard bench for the BHT update FIFO: driver feeds a queue model, monitor checks outputs.
module tb_bp_fe_bht_update_fifo;
  import bp_fe_bht_update_fifo_pkg::*;

  localparam int ELS   = 4;
  localparam int LIMIT = 3;
  localparam int IW = bht_idx_width_gp, OW = bht_offset_width_gp, RW = bht_row_width_gp;

  logic clk_i = 1'b0;
  logic reset_i, init_done_i, enq_v_i, enq_ready_and_o, enq_correct_i;
  logic w_v_o, w_correct_o, w_force_o, w_yumi_i;
  logic [IW-1:0] enq_idx_i, w_idx_o;
  logic [OW-1:0] enq_offset_i, w_offset_o;
  logic [RW-1:0] enq_val_i, w_val_o;
  logic [bsg_width(ELS)-1:0] count_o;

  always #5 clk_i = ~clk_i;

  bp_fe_bht_update_fifo #(.els_p(ELS), .starve_limit_p(LIMIT)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .init_done_i(init_done_i),
    .enq_v_i(enq_v_i), .enq_ready_and_o(enq_ready_and_o),
    .enq_idx_i(enq_idx_i), .enq_offset_i(enq_offset_i),
    .enq_val_i(enq_val_i), .enq_correct_i(enq_correct_i),
    .w_v_o(w_v_o), .w_idx_o(w_idx_o), .w_offset_o(w_offset_o),
    .w_val_o(w_val_o), .w_correct_o(w_correct_o), .w_force_o(w_force_o),
    .w_yumi_i(w_yumi_i), .count_o(count_o)
  );

  // Reference model: ordered list of pending updates, head age in cycles.
  bp_fe_bht_update_s sb_q[$];
  int mdl_cnt = 0;
  int age     = 0;
  int n_chk   = 0;
  int n_fail  = 0;
  int seed_v;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic bit match_tail();
    return sb_q.size() > 0 && sb_q[$].idx == enq_idx_i && sb_q[$].offset == enq_offset_i;
  endfunction

  function automatic bit exp_ready();
    if (mdl_cnt < ELS) return 1'b1;
`ifdef BP_FE_BHT_UPD_COALESCE_EN
    return match_tail();
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit exp_wv();
    return mdl_cnt > 0 && init_done_i === 1'b1 && reset_i === 1'b0;
  endfunction

  // Monitor: compare outputs mid-cycle, retire the head on each dequeue.
  always begin
    bit wv;
    @(negedge clk_i);
    #2;
    wv = exp_wv();
    chk("ready", 32'(enq_ready_and_o), 32'(exp_ready()));
    chk("w_v", 32'(w_v_o), 32'(wv));
    chk("force", 32'(w_force_o), 32'(wv && age >= LIMIT));
    chk("count", 32'(count_o), 32'(mdl_cnt));
    if (wv && sb_q.size() > 0) begin
      chk("head", 32'({w_idx_o, w_offset_o, w_val_o, w_correct_o}), 32'(sb_q[0]));
      if (w_yumi_i) void'(sb_q.pop_front());
    end
  end

  // One clock of stimulus; yumi is only raised when the model expects a valid head.
  task automatic cyc(input logic v, input logic [IW-1:0] idx, input logic [OW-1:0] off,
                     input logic [RW-1:0] val, input logic cor, input logic yreq);
    bit acc, coal, yum, wv;
    @(negedge clk_i);
    enq_v_i = v; enq_idx_i = idx; enq_offset_i = off; enq_val_i = val; enq_correct_i = cor;
    wv  = exp_wv();
    yum = yreq && wv;
    w_yumi_i = yum;
    acc  = v && exp_ready() && !reset_i;
    coal = 1'b0;
`ifdef BP_FE_BHT_UPD_COALESCE_EN
    coal = acc && mdl_cnt > 0 && match_tail() && !(mdl_cnt == 1 && yum);
`endif
    @(posedge clk_i);
    #1;
    if (reset_i) begin
      sb_q.delete();
      mdl_cnt = 0;
      age = 0;
    end else begin
      if (coal) begin
        sb_q[$].val = val;
        sb_q[$].correct = cor;
      end else if (acc) begin
        sb_q.push_back('{idx: idx, offset: off, val: val, correct: cor});
        mdl_cnt++;
      end
      if (yum) begin
        mdl_cnt--;
        age = 0;
      end else if (wv) begin
        age++;
      end
    end
  endtask

  task automatic idle(input int n, input logic yreq);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, '0, 1'b0, yreq);
  endtask

  initial begin
    reset_i = 1'b1; init_done_i = 1'b0; enq_v_i = 1'b0; w_yumi_i = 1'b0;
    enq_idx_i = '0; enq_offset_i = '0; enq_val_i = '0; enq_correct_i = 1'b0;
    idle(2, 1'b0);
    reset_i = 1'b0;

    // Accumulate while BHT init is pending, then drain in order.
    cyc(1'b1, 9'd10, 2'd0, 8'hA1, 1'b1, 1'b0);
    cyc(1'b1, 9'd11, 2'd1, 8'hB2, 1'b0, 1'b0);
    idle(1, 1'b0);
    init_done_i = 1'b1;
    idle(3, 1'b1);

    // Fill to capacity; a 5th enqueue alongside a yumi is refused, then accepted.
    for (int i = 0; i < ELS; i++) cyc(1'b1, IW'(20 + i), OW'(i), RW'(8'h30 + i), i[0], 1'b0);
    cyc(1'b1, 9'd40, 2'd3, 8'h55, 1'b1, 1'b1);
    cyc(1'b1, 9'd40, 2'd3, 8'h55, 1'b1, 1'b0);

    // Starve the head into force, release it, next head starts fresh.
    idle(6, 1'b0);
    idle(1, 1'b1);
    idle(2, 1'b0);
    idle(ELS + 1, 1'b1);

    // Streaming: one in, one out every cycle across several pointer wraps.
    cyc(1'b1, 9'd100, 2'd0, 8'h00, 1'b0, 1'b0);
    for (int i = 1; i <= 50; i++) cyc(1'b1, IW'(100 + i), OW'(i), RW'(i * 7), i[1], 1'b1);
    idle(2, 1'b1);

    // Reset flushes queued entries.
    for (int i = 0; i < 3; i++) cyc(1'b1, IW'(200 + i), 2'd2, RW'(8'hE0 + i), 1'b1, 1'b0);
    reset_i = 1'b1;
    idle(1, 1'b1);
    reset_i = 1'b0;
    cyc(1'b1, 9'd300, 2'd1, 8'h77, 1'b0, 1'b0);
    idle(2, 1'b1);

`ifdef BP_FE_BHT_UPD_COALESCE_EN
    // Repeat idx/offset merges into the tail, also while full.
    cyc(1'b1, 9'd5, 2'd1, 8'h11, 1'b0, 1'b0);
    cyc(1'b1, 9'd5, 2'd1, 8'h22, 1'b1, 1'b0);
    for (int i = 0; i < ELS - 1; i++) cyc(1'b1, IW'(50 + i), 2'd0, RW'(i), 1'b0, 1'b0);
    cyc(1'b1, 9'd52, 2'd0, 8'h99, 1'b1, 1'b0);
    idle(ELS + 1, 1'b1);
`endif

    // Randomized traffic over a small key space.
    seed_v = 1;
    void'($urandom(seed_v));
    for (int i = 0; i < 600; i++) begin
      reset_i     = ($urandom_range(99) == 0);
      init_done_i = ($urandom_range(9) != 0);
      cyc(($urandom_range(2) != 0), IW'($urandom_range(3)), OW'($urandom_range(1)),
          RW'($urandom), 1'($urandom), ($urandom_range(4) > 1));
    end
    reset_i = 1'b0;
    init_done_i = 1'b1;
    idle(ELS + 4, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bp_fe_bht_update_fifo.md
# bp_fe_bht_update_fifo

Buffers branch-history-table training updates produced by the FE redirect/commit path and replays them, in order, into the BHT write port. The BHT refuses a write whenever a read hits the same row in the same cycle, unless the write is forced. This block holds pending updates across those refusals. It escalates a starved head entry to a forced write after a bounded number of refusals, so prediction reads can never starve training indefinitely.

## Interface
- bp_params_p, e_bp_default_cfg: processor config; supplies bht_idx_width_p, bht_offset_width_p, bht_row_width_p.
- els_p, 4: queue depth; power of two, at least 2.
- starve_limit_p, 3: consecutive refused cycles before the head is forced; at least 1.

Ports:
- clk_i  in  1  single clock; everything is posedge.
- reset_i  in  1  synchronous, active-high reset.
- init_done_i  in  1  BHT initialisation complete; gates w_v_o.
- enq_v_i  in  1  update valid (valid->ready_and handshake).
- enq_ready_and_o  out  1  space available.
- enq_idx_i  in  bht_idx_width_p  row index.
- enq_offset_i  in  bht_offset_width_p  counter within row.
- enq_val_i  in  bht_row_width_p  row value read at prediction time.
- enq_correct_i  in  1  prediction was correct.
- w_v_o  out  1  head valid toward BHT.
- w_idx_o, w_offset_o, w_val_o, w_correct_o  out  as above  head fields.
- w_force_o  out  1  head must win a read/write row conflict.
- w_yumi_i  in  1  BHT consumed the head this cycle.
- count_o  out  `BSG_WIDTH(els_p)  entries held.

## Operation
- Circular buffer with rptr and wptr, each $clog2(els_p) bits, plus a count register of `BSG_WIDTH(els_p)` bits.
  - Pointers wrap modulo els_p.
  - full = (count == els_p); empty = (count == 0).
- enq_ready_and_o = ~full.
  - It does not depend on w_yumi_i, so there is no combinational path.
  - If full and the head is dequeued in the same cycle, the new enqueue is still refused that cycle.
- Enqueue when enq_v_i & enq_ready_and_o: write the entry at wptr, then wptr+1 and count+1.
- Presentation: w_v_o = ~empty & init_done_i. The head fields always reflect the entry at rptr (asynchronous read).
- Dequeue on w_yumi_i: rptr+1 and count-1.
  - w_yumi_i without w_v_o is illegal; assert it in simulation.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance.
- No bypass: an enqueue into an empty queue appears on w_v_o the next cycle.
- Starvation counter starve_r, width `BSG_WIDTH(starve_limit_p)`:
  - Clears on reset and on w_yumi_i.
  - Increments on w_v_o & ~w_yumi_i.
  - Saturates at starve_limit_p.
- w_force_o = w_v_o & (starve_r == starve_limit_p).
  - Force is a function of head age only; it never depends on enqueue activity.
- While init_done_i is low, entries accumulate and starve_r holds.
- Reset mid-operation flushes all entries. In-flight data is discarded and no write is issued in the reset cycle.

## Timing
- Reset values:
  - enq_ready_and_o = 1.
  - w_v_o = 0, w_force_o = 0, count_o = 0.
  - Head data outputs are don't-care (X permitted).
- Latency from enqueue to w_v_o: 1 cycle, given init_done_i.
- Minimum residency: 1 cycle.
- Throughput: 1 update per cycle when the BHT accepts every cycle.
- Forcing starts on the (starve_limit_p+1)-th consecutive cycle the head is presented without yumi.

## Configuration
- Macro: BP_FE_BHT_UPD_COALESCE_EN.
- When defined, an enqueue whose idx/offset equal the tail entry's overwrites the tail's val/correct in place instead of allocating.
  - Pointers and count are unchanged.
  - The enqueue is accepted even when the queue is full.
  - Coalescing is disallowed when the tail is also the head and w_yumi_i is high that cycle; in that case a normal allocation is made.
  - When the tail is also the head, coalescing does not reset starve_r.
- When undefined, every accepted enqueue allocates, and there is no compare logic.

## Structure
- Update struct type: add `declare_bp_fe_bht_update_s(idx, offset, row)` to bp_fe_defines.svh. Fields: idx, offset, val, correct.
  - This block and the BHT training producer share this type.
- Storage: bsg_mem_1r1w with read_write_same_addr_p=0 and an asynchronous read port.
- Sub-module: none.
- The pointer, count and starvation logic is inline, written as one always_ff block plus combinational next-state logic.

## Test plan
- Post-reset with init_done_i=0: enqueue 2 entries, then raise init_done_i. Response: w_v_o=1 the next cycle, with entries drained in order across 2 cycles with yumi, then count_o=0.
- Fill to 4 entries with w_yumi_i=0: enq_ready_and_o drops after the 4th. A 5th enqueue in the same cycle as a yumi is refused; it is accepted one cycle later.
- Hold w_yumi_i=0 on a valid head: w_force_o is 0 for cycles 1-3 and 1 from cycle 4. A yumi clears it the next cycle, and the next head starts at 0.
- Continuous enqueue every cycle with yumi every cycle for 50 cycles: count_o stays at 1, FIFO order is preserved across pointer wrap, and w_force_o never asserts.
- Reset asserted with 3 entries queued: the next cycle shows count_o=0 and w_v_o=0, and the old entries never reappear.
- With COALESCE_EN: enqueue idx=5/offset=1 twice with different val. Response: count_o=1, and the head shows the second val. Repeat while full: the enqueue is accepted and count is unchanged.
